divider_ctrl: RTL and testbench

DIVIDER_CTRL -- requirements
Module: divider_ctrl

---
 rtl/pong_pkg.sv | 23 ++
 rtl/divider_seg_gen.sv | 33 +++
 rtl/divider_ctrl.sv | 174 +++++++++++++++++
 tb/tb_divider_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong video blocks: FSM encoding, screen geometry
// and a small helper for the FLASH blink phase.
package pong_pkg;

  localparam int SCREEN_WIDTH  = 800;
  localparam int SCREEN_HEIGHT = 600;
  localparam int COORD_W       = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLASH = 2'd2
  } div_state_e;

  // The divider is visible during FLASH only in odd blink half-periods.
  function automatic logic blink_visible(input logic [COORD_W-1:0] cnt,
                                         input logic [COORD_W-1:0] period);
    logic [COORD_W-1:0] half_idx;
    half_idx = cnt / period;
    return half_idx[0];
  endfunction

endpackage

// File: rtl/divider_seg_gen.sv
// Segment bound generator: maps a segment index to its exclusive vertical
// bounds and flags whether the following segment would run off the screen.
module divider_seg_gen
  import pong_pkg::*;
#(
  parameter int screenHeight = SCREEN_HEIGHT,
  parameter int segLen       = 20,
  parameter int gapLen       = 20
) (
  input  logic [COORD_W-1:0] seg_idx_i,
  output logic [COORD_W-1:0] top_o,
  output logic [COORD_W-1:0] bottom_o,
  output logic               last_o
);

  localparam logic [COORD_W-1:0] SEG_W   = COORD_W'(segLen);
  localparam logic [COORD_W-1:0] GAP_W   = COORD_W'(gapLen);
  localparam logic [COORD_W-1:0] PITCH_W = COORD_W'(segLen + gapLen);
  localparam logic [COORD_W-1:0] HEIGHT_W = COORD_W'(screenHeight);

  logic [COORD_W-1:0] start_s;
  logic [COORD_W-1:0] next_end_s;

  // First line of the segment, its exclusive bounds, and the end of the next one.
  always_comb begin
    start_s    = GAP_W + (seg_idx_i * PITCH_W);
    top_o      = start_s - 11'd1;
    bottom_o   = start_s + SEG_W;
    next_end_s = bottom_o + PITCH_W;
    last_o     = (next_end_s > HEIGHT_W);
  end

endmodule

// File: rtl/divider_ctrl.sv
// Centre-net divider controller: walks a dashed line of segments down each
// frame and blinks it for a number of frames after every point scored.
module divider_ctrl
  import pong_pkg::*;
#(
  parameter int screenWidth  = SCREEN_WIDTH,
  parameter int screenHeight = SCREEN_HEIGHT,
  parameter int dividerWidth = 10,
  parameter int segLen       = 20,
  parameter int gapLen       = 20,
  parameter int flashFrames  = 60,
  parameter int blinkPeriod  = 8
) (
  input  logic         pixelClock,
  input  logic         Reset,
  input  logic [10:0]  xPosition,
  input  logic [9:0]   yPosition,
  input  logic         frameStart,
  input  logic         enable,
  input  logic         pointScored,
  output logic [10:0]  topD,
  output logic [10:0]  bottomD,
  output logic [10:0]  leftD,
  output logic [10:0]  rightD,
  output logic         dividerOn,
  output logic [1:0]   state
);

  localparam logic [10:0] LEFT_BOUND  = 11'((screenWidth - dividerWidth) / 2 - 1);
  localparam logic [10:0] RIGHT_BOUND = LEFT_BOUND + 11'(dividerWidth) + 11'd1;
  localparam logic [10:0] FLASH_LAST  = 11'(flashFrames);
  localparam logic [10:0] BLINK_W     = 11'(blinkPeriod);

  div_state_e  state_q, state_d;
  logic [10:0] flash_cnt_q, flash_cnt_d;
  logic [10:0] seg_idx_q, seg_idx_d;
  logic        seg_valid_q, seg_valid_d;
  logic        seg_last_q;
  logic [10:0] top_q, bottom_q, left_q, right_q;
  logic        on_q, show_s;
  logic [10:0] seg_top_s, seg_bottom_s;
  logic        seg_last_s;
  logic        unused_s;

  // Bounds are purely vertical; the column is decoded by the pixel mixer.
  assign unused_s = ^xPosition;

  divider_seg_gen #(
    .screenHeight (screenHeight),
    .segLen       (segLen),
    .gapLen       (gapLen)
  ) u_seg_gen (
    .seg_idx_i (seg_idx_d),
    .top_o     (seg_top_s),
    .bottom_o  (seg_bottom_s),
    .last_o    (seg_last_s)
  );

  // FSM next state and flash frame counter; disable overrides every event.
  always_comb begin
    state_d     = state_q;
    flash_cnt_d = flash_cnt_q;
    if (!enable) begin
      state_d     = ST_IDLE;
      flash_cnt_d = 11'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frameStart) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pointScored) begin
            state_d     = ST_FLASH;
            flash_cnt_d = 11'd0;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLASH: begin
          if (pointScored) begin
            flash_cnt_d = 11'd0;
          end else if (frameStart) begin
            if (flash_cnt_q + 11'd1 == FLASH_LAST) begin
              state_d     = ST_RUN;
              flash_cnt_d = 11'd0;
            end else begin
              flash_cnt_d = flash_cnt_q + 11'd1;
            end
          end else begin
            flash_cnt_d = flash_cnt_q;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          flash_cnt_d = 11'd0;
        end
      endcase
    end
  end

  // Segment sequencer: restart at each enabled frame, step once the raster
  // passes the bottom of a visible segment, stop after the last one.
  always_comb begin
    seg_idx_d   = seg_idx_q;
    seg_valid_d = seg_valid_q;
    if (!enable) begin
      seg_idx_d   = 11'd0;
      seg_valid_d = 1'b0;
    end else if (frameStart) begin
      seg_idx_d   = 11'd0;
      seg_valid_d = 1'b1;
    end else if (on_q && ({1'b0, yPosition} >= bottom_q)) begin
      if (seg_last_q) begin
        seg_valid_d = 1'b0;
      end else begin
        seg_idx_d = seg_idx_q + 11'd1;
      end
    end else begin
      seg_idx_d   = seg_idx_q;
      seg_valid_d = seg_valid_q;
    end
  end

  // Visibility of the next bounds: RUN shows segments, FLASH only in odd half-periods.
  always_comb begin
    show_s = 1'b0;
    if (seg_valid_d && (state_d == ST_RUN)) begin
      show_s = 1'b1;
    end else if (seg_valid_d && (state_d == ST_FLASH)) begin
      show_s = blink_visible(flash_cnt_d, BLINK_W);
    end else begin
      show_s = 1'b0;
    end
  end

  // State, counters and registered bounds with synchronous reset.
  always_ff @(posedge pixelClock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      flash_cnt_q <= 11'd0;
      seg_idx_q   <= 11'd0;
      seg_valid_q <= 1'b0;
      seg_last_q  <= 1'b0;
      top_q       <= 11'd0;
      bottom_q    <= 11'd0;
      left_q      <= 11'd0;
      right_q     <= 11'd0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      flash_cnt_q <= flash_cnt_d;
      seg_idx_q   <= seg_idx_d;
      seg_valid_q <= seg_valid_d;
      seg_last_q  <= seg_last_s;
      top_q       <= show_s ? seg_top_s    : 11'd0;
      bottom_q    <= show_s ? seg_bottom_s : 11'd0;
      left_q      <= show_s ? LEFT_BOUND   : 11'd0;
      right_q     <= show_s ? RIGHT_BOUND  : 11'd0;
      on_q        <= show_s;
    end
  end

  assign topD      = top_q;
  assign bottomD   = bottom_q;
  assign leftD     = left_q;
  assign rightD    = right_q;
  assign dividerOn = on_q;
  assign state     = state_q;

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed self-checking bench for divider_ctrl with default parameters.
module tb_divider_ctrl;

  logic        pixelClock = 1'b0;
  logic        Reset = 1'b1;
  logic [10:0] xPosition = 11'd0;
  logic [9:0]  yPosition = 10'd0;
  logic        frameStart = 1'b0;
  logic        enable = 1'b0;
  logic        pointScored = 1'b0;
  logic [10:0] topD, bottomD, leftD, rightD;
  logic        dividerOn;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  divider_ctrl dut (
    .pixelClock  (pixelClock),
    .Reset       (Reset),
    .xPosition   (xPosition),
    .yPosition   (yPosition),
    .frameStart  (frameStart),
    .enable      (enable),
    .pointScored (pointScored),
    .topD        (topD),
    .bottomD     (bottomD),
    .leftD       (leftD),
    .rightD      (rightD),
    .dividerOn   (dividerOn),
    .state       (state)
  );

  always #5 pixelClock = ~pixelClock;

  task automatic tick();
    @(posedge pixelClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame_pulse();
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
  endtask

  task automatic score_pulse();
    pointScored = 1'b1;
    tick();
    pointScored = 1'b0;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_on"}, 32'(dividerOn), 32'd0);
    chk({tag, "_top"}, 32'(topD), 32'd0);
    chk({tag, "_bot"}, 32'(bottomD), 32'd0);
    chk({tag, "_left"}, 32'(leftD), 32'd0);
    chk({tag, "_right"}, 32'(rightD), 32'd0);
  endtask

  initial begin
    // Reset and idle behaviour
    tick();
    tick();
    chk_empty("reset");
    chk("reset_state", 32'(state), 32'd0);
    Reset = 1'b0;
    frame_pulse();
    chk("idle_noen_state", 32'(state), 32'd0);
    chk("idle_noen_on", 32'(dividerOn), 32'd0);
    enable = 1'b1;
    tick();
    chk("idle_en_nofs_state", 32'(state), 32'd0);

    // First enabled frame loads segment 0
    frame_pulse();
    chk("run_state", 32'(state), 32'd1);
    chk("seg0_top", 32'(topD), 32'd19);
    chk("seg0_bot", 32'(bottomD), 32'd40);
    chk("seg0_left", 32'(leftD), 32'd394);
    chk("seg0_right", 32'(rightD), 32'd405);
    chk("seg0_on", 32'(dividerOn), 32'd1);

    // Advance only once y reaches bottomD
    yPosition = 10'd39;
    tick();
    chk("y39_top", 32'(topD), 32'd19);
    yPosition = 10'd40;
    tick();
    chk("seg1_top", 32'(topD), 32'd59);
    chk("seg1_bot", 32'(bottomD), 32'd80);
    for (int k = 1; k <= 13; k++) begin
      yPosition = 10'(40 + 40 * k);
      tick();
      chk("walk_top", 32'(topD), 32'(19 + 40 * (k + 1)));
    end
    chk("seg14_top", 32'(topD), 32'd579);
    chk("seg14_bot", 32'(bottomD), 32'd600);
    yPosition = 10'd600;
    tick();
    chk_empty("past_last");
    yPosition = 10'd0;
    tick();
    chk("still_empty_on", 32'(dividerOn), 32'd0);

    // New frame restarts, then a point enters FLASH
    frame_pulse();
    chk("frame2_top", 32'(topD), 32'd19);
    score_pulse();
    chk("flash_state", 32'(state), 32'd2);
    chk("flash0_on", 32'(dividerOn), 32'd0);
    for (int n = 1; n <= 59; n++) begin
      frame_pulse();
      chk("flash_blink_on", 32'(dividerOn), 32'(((n / 8) % 2) == 1));
      chk("flash_stay", 32'(state), 32'd2);
      if (n == 8) begin
        chk("flash8_top", 32'(topD), 32'd19);
        yPosition = 10'd40;
        tick();
        chk("flash8_adv_top", 32'(topD), 32'd59);
        yPosition = 10'd0;
      end
    end
    frame_pulse();
    chk("flash_done_state", 32'(state), 32'd1);
    chk("flash_done_top", 32'(topD), 32'd19);

    // Point during FLASH restarts the flash count
    score_pulse();
    for (int n = 1; n <= 30; n++) frame_pulse();
    chk("flash30_state", 32'(state), 32'd2);
    score_pulse();
    chk("rescore_state", 32'(state), 32'd2);
    chk("rescore_on", 32'(dividerOn), 32'd0);
    for (int n = 1; n <= 59; n++) begin
      frame_pulse();
      if (n == 8) chk("rescore8_on", 32'(dividerOn), 32'd1);
    end
    chk("rescore59_state", 32'(state), 32'd2);
    frame_pulse();
    chk("rescore60_state", 32'(state), 32'd1);

    // Simultaneous frameStart and pointScored in RUN
    yPosition = 10'd40;
    tick();
    chk("pre_sim_top", 32'(topD), 32'd59);
    yPosition = 10'd0;
    frameStart = 1'b1;
    pointScored = 1'b1;
    tick();
    frameStart = 1'b0;
    pointScored = 1'b0;
    chk("sim_state", 32'(state), 32'd2);
    chk("sim_on", 32'(dividerOn), 32'd0);
    for (int n = 1; n <= 8; n++) frame_pulse();
    chk("sim8_top", 32'(topD), 32'd19);

    // Disable overrides frameStart and pointScored
    enable = 1'b0;
    frameStart = 1'b1;
    pointScored = 1'b1;
    tick();
    frameStart = 1'b0;
    pointScored = 1'b0;
    chk("dis_state", 32'(state), 32'd0);
    chk_empty("dis");
    enable = 1'b1;
    frame_pulse();
    yPosition = 10'd40;
    tick();
    yPosition = 10'd65;
    chk("midseg_top", 32'(topD), 32'd59);
    enable = 1'b0;
    tick();
    chk("dis_mid_state", 32'(state), 32'd0);
    chk_empty("dis_mid");

    // Reset in the middle of a visible FLASH phase
    enable = 1'b1;
    yPosition = 10'd0;
    frame_pulse();
    score_pulse();
    for (int n = 1; n <= 8; n++) frame_pulse();
    chk("pre_rst_on", 32'(dividerOn), 32'd1);
    Reset = 1'b1;
    tick();
    chk("rst_flash_state", 32'(state), 32'd0);
    chk_empty("rst_flash");
    Reset = 1'b0;
    tick();
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_on", 32'(dividerOn), 32'd0);
    frame_pulse();
    chk("post_rst_run", 32'(state), 32'd1);
    chk("post_rst_top", 32'(topD), 32'd19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
